// File: rtl/mac_pkg.sv
// Shared constants for the signed multiply pipeline feeding the MAC accumulator.
// Optional first-of-accumulation tag is enabled with MAC_MULT_FIRST_EN.
package mac_pkg;

    localparam int unsigned A_W_DEF = 16;
    localparam int unsigned CNT_W   = 16;

    // Full-precision signed product width for a given operand width.
    function automatic int unsigned p_w(input int unsigned a_w);
        return 2 * a_w;
    endfunction

endpackage

// File: rtl/mac_pipe_reg.sv
// Single valid/ready register stage; accepts when empty or when its content drains this cycle.
module mac_pipe_reg #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready_c,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    assign in_ready_c = !out_valid || out_ready;

    // Data only loads on an actual transfer so a stalled or idle stage keeps its last value.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (in_ready_c) begin
            out_valid <= in_valid;
            if (in_valid) begin
                out_data <= in_data;
            end
        end
    end

endmodule

// File: rtl/mac_mult.sv
// Two-stage signed multiplier (operand capture, product capture) with valid/ready on both sides.
// Define MAC_MULT_FIRST_EN to carry an accumulation-start flag alongside each pair.
module mac_mult
    import mac_pkg::*;
#(
    parameter int unsigned A_W = A_W_DEF
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic signed [A_W-1:0]      in_a,
    input  logic signed [A_W-1:0]      in_b,
`ifdef MAC_MULT_FIRST_EN
    input  logic                       in_first,
    output logic                       out_first,
`endif
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic signed [2*A_W-1:0]    out_prod,
    output logic [CNT_W-1:0]           prod_count,
    input  logic                       scan_in0,
    input  logic                       scan_en,
    output logic                       scan_out0
);

    localparam int unsigned P_W = p_w(A_W);

`ifdef MAC_MULT_FIRST_EN
    localparam int unsigned S1_W = 2 * A_W + 1;
    localparam int unsigned S2_W = P_W + 1;
`else
    localparam int unsigned S1_W = 2 * A_W;
    localparam int unsigned S2_W = P_W;
`endif

    logic [S1_W-1:0]        s1_in;
    logic [S1_W-1:0]        s1_q;
    logic                   s1_valid;
    logic                   s1_ready_c;
    logic [S2_W-1:0]        s2_in;
    logic [S2_W-1:0]        s2_q;
    logic                   s2_ready_c;
    logic signed [A_W-1:0]  s1_a;
    logic signed [A_W-1:0]  s1_b;
    logic signed [P_W-1:0]  prod_c;
    logic                   unused_scan_c;

`ifdef MAC_MULT_FIRST_EN
    assign s1_in     = {in_first, in_a, in_b};
    assign s2_in     = {s1_q[S1_W-1], prod_c};
    assign out_first = s2_q[S2_W-1];
`else
    assign s1_in     = {in_a, in_b};
    assign s2_in     = prod_c;
`endif

    assign s1_a   = s1_q[2*A_W-1:A_W];
    assign s1_b   = s1_q[A_W-1:0];
    // Sign-extend both operands to product width so the most negative square stays exact.
    assign prod_c = P_W'(s1_a) * P_W'(s1_b);

    assign out_prod = s2_q[P_W-1:0];
    assign in_ready = s1_ready_c;

    mac_pipe_reg #(.W(S1_W)) u_s1 (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready_c (s1_ready_c),
        .in_data    (s1_in),
        .out_valid  (s1_valid),
        .out_ready  (s2_ready_c),
        .out_data   (s1_q)
    );

    mac_pipe_reg #(.W(S2_W)) u_s2 (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (s1_valid),
        .in_ready_c (s2_ready_c),
        .in_data    (s2_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (s2_q)
    );

    // Delivered-product counter, free-running wrap.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prod_count <= '0;
        end else if (out_valid && out_ready) begin
            prod_count <= prod_count + CNT_W'(1);
        end
    end

    // Scan chain is stitched at DFT insertion.
    assign unused_scan_c = scan_in0 ^ scan_en;
    assign scan_out0     = 1'b0;

endmodule
